// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
//   Control/status bundle of the countdown timer.
//   master : drives en, load, load_val, start, stop, periodic; observes status.
//   slave  : the timer itself; observes control, drives out, busy, tc, done.
//   Parameter DATA_WIDTH : width of load_val and out.
// -----------------------------------------------------------------------------
interface countdown_timer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  start;
  logic                  stop;
  logic                  periodic;
  logic [DATA_WIDTH-1:0] out;
  logic                  busy;
  logic                  tc;
  logic                  done;

  modport master (
    output en, load, load_val, start, stop, periodic,
    input  out, busy, tc, done
  );

  modport slave (
    input  en, load, load_val, start, stop, periodic,
    output out, busy, tc, done
  );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter with IDLE/ARMED/RUN/DONE control. Counts the loaded
//   value down to zero, pulses tc, then reloads (periodic) or stops (one-shot).
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous reset, active-high
//     bus  - countdown_timer_if.slave (en, load, load_val, start, stop,
//            periodic in; out, busy, tc, done out, all registered)
//
//   Build option: define COUNTDOWN_PRESCALE_EN to insert a prescaler so one
//   count tick happens every PRESCALE enabled RUN cycles. Without it every
//   enabled RUN cycle is a tick and PRESCALE is unused.
//
//   Per-cycle priority: rst > load > stop > start > counting.
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 4
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
  logic                  busy_q, busy_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  tick;

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PRE_LAST);
  assign tick     = (state_q == RUN) && bus.en && pre_wrap;
`else
  assign tick     = (state_q == RUN) && bus.en;
`endif

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
    pre_d    = pre_q;
`endif

    if (bus.load) begin
      // Load aborts anything in flight, including a coinciding terminal tick.
      reload_d = bus.load_val;
      out_d    = bus.load_val;
      state_d  = ARMED;
      done_d   = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
      pre_d    = '0;
`endif
    end else if (bus.stop) begin
      // Stop owns the cycle: it also suppresses a coinciding terminal tick.
      if (state_q == RUN) state_d = ARMED;
    end else if (bus.start && (state_q == ARMED || state_q == DONE)) begin
      state_d = RUN;
      if (state_q == DONE) begin
        out_d  = reload_q;
        done_d = 1'b0;
      end
`ifdef COUNTDOWN_PRESCALE_EN
      pre_d   = '0;
`endif
    end else if (state_q == RUN && bus.en) begin
`ifdef COUNTDOWN_PRESCALE_EN
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
`endif
      if (tick) begin
        if (out_q > DATA_WIDTH'(1)) begin
          out_d = out_q - 1'b1;
        end else begin
          // Terminal tick: out of 0 or 1 both terminate, so no wrap below 0.
          tc_d = 1'b1;
          if (bus.periodic) begin
            out_d = reload_q;
          end else begin
            out_d   = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
      pre_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_PRESCALE_EN
      pre_q    <= pre_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed scenarios with expected values taken from the timer's timing
//   rules, followed by a randomized run compared every cycle against a
//   behavioural model (count, reload value and a run/armed/finished mode).
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int DW       = 8;
  localparam int PRESCALE = 4;
`ifdef COUNTDOWN_PRESCALE_EN
  localparam int P = PRESCALE;
`else
  localparam int P = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_timer_if #(.DATA_WIDTH(DW)) bus ();

  countdown_timer #(.DATA_WIDTH(DW), .PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  int m_count, m_reload, m_pre;
  bit m_run, m_armed, m_fin, m_tc, m_done;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input bit e, input bit ld, input int lv,
                        input bit st, input bit sp, input bit per);
    bus.en       = e;
    bus.load     = ld;
    bus.load_val = lv[DW-1:0];
    bus.start    = st;
    bus.stop     = sp;
    bus.periodic = per;
  endtask

  // Apply the rules to the inputs sampled at this edge.
  task automatic model_edge();
    bit tk;
    m_tc = 1'b0;
    if (rst) begin
      m_count = 0; m_reload = 0; m_pre = 0;
      m_run = 0; m_armed = 0; m_fin = 0; m_done = 0;
    end else if (bus.load) begin
      m_reload = int'(bus.load_val);
      m_count  = m_reload;
      m_run = 0; m_armed = 1; m_fin = 0; m_done = 0; m_pre = 0;
    end else if (bus.stop) begin
      if (m_run) begin m_run = 0; m_armed = 1; end
    end else if (bus.start && (m_armed || m_fin)) begin
      if (m_fin) begin m_count = m_reload; m_done = 0; end
      m_run = 1; m_armed = 0; m_fin = 0; m_pre = 0;
    end else if (m_run && bus.en) begin
      m_pre = m_pre + 1;
      tk = 0;
      if (m_pre >= P) begin m_pre = 0; tk = 1; end
      if (tk) begin
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (bus.periodic) m_count = m_reload;
          else begin
            m_count = 0; m_run = 0; m_fin = 1; m_done = 1;
          end
        end
      end
    end
  endtask

  // One clock: edge, model update, then settle before anyone samples.
  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_tc(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      clk_cycle();
      if (bus.tc === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    clk_cycle(); clk_cycle();
    n_cmp++;
    if ({bus.out, bus.busy, bus.tc, bus.done} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_values: got out=%0d busy=%b tc=%b done=%b, want all 0",
               bus.out, bus.busy, bus.tc, bus.done);
    end
    rst = 1'b0;
    set_in(1, 1, 5, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    n_cmp++;
    if (bus.out !== 8'd5 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_prerun: got out=%0d busy=%b, want 5/1", bus.out, bus.busy);
    end
    set_in(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    n_cmp++;
    if ({bus.out, bus.busy, bus.tc, bus.done} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_midrun: got out=%0d busy=%b tc=%b done=%b, want all 0",
               bus.out, bus.busy, bus.tc, bus.done);
    end
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0); clk_cycle();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_start_ignored: got busy=%b out=%0d, want 0/0", bus.busy, bus.out);
    end
  endtask

  task automatic test_one_shot();
    logic [10:0] exp;
    set_in(1, 1, 3, 0, 0, 0); clk_cycle();
    n_cmp++;
    if (bus.out !== 8'd3 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL oneshot_load: got out=%0d busy=%b, want 3/0", bus.out, bus.busy);
    end
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    // k counts cycles since busy rose; ticks land on multiples of P.
    for (int k = 1; k <= 3 * P + 4; k++) begin
      clk_cycle();
      exp = {DW'((k / P >= 3) ? 0 : 3 - k / P), k < 3 * P, k == 3 * P, k >= 3 * P};
      n_cmp++;
      if ({bus.out, bus.busy, bus.tc, bus.done} !== exp) begin
        n_bad++;
        $display("FAIL oneshot_seq k=%0d: got {out,busy,tc,done}=%h, want %h",
                 k, {bus.out, bus.busy, bus.tc, bus.done}, exp);
      end
    end
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.out, bus.busy, bus.done} !== {8'd3, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL oneshot_restart: got out=%0d busy=%b done=%b, want 3/1/0",
               bus.out, bus.busy, bus.done);
    end
    repeat (3 * P) clk_cycle();
  endtask

  task automatic test_periodic();
    logic [10:0] exp;
    set_in(1, 1, 2, 0, 0, 1); clk_cycle();
    set_in(1, 0, 0, 1, 0, 1); clk_cycle();
    set_in(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 6 * P; k++) begin
      clk_cycle();
      exp = {DW'(((k / P) % 2 == 0) ? 2 : 1), 1'b1, (k % (2 * P)) == 0, 1'b0};
      n_cmp++;
      if ({bus.out, bus.busy, bus.tc, bus.done} !== exp) begin
        n_bad++;
        $display("FAIL periodic2 k=%0d: got {out,busy,tc,done}=%h, want %h",
                 k, {bus.out, bus.busy, bus.tc, bus.done}, exp);
      end
    end
    set_in(1, 1, 0, 0, 0, 1); clk_cycle();
    set_in(1, 0, 0, 1, 0, 1); clk_cycle();
    set_in(1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4 * P; k++) begin
      clk_cycle();
      exp = {DW'(0), 1'b1, (k % P) == 0, 1'b0};
      n_cmp++;
      if ({bus.out, bus.busy, bus.tc, bus.done} !== exp) begin
        n_bad++;
        $display("FAIL periodic0 k=%0d: got {out,busy,tc,done}=%h, want %h",
                 k, {bus.out, bus.busy, bus.tc, bus.done}, exp);
      end
    end
    set_in(1, 0, 0, 0, 1, 1); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL periodic_stop: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_pause_resume();
    int lat;
    set_in(1, 1, 5, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (2 * P) clk_cycle();
    set_in(1, 0, 0, 0, 1, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      clk_cycle();
      n_cmp++;
      if ({bus.out, bus.busy, bus.tc} !== {8'd3, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL pause_hold k=%0d: got out=%0d busy=%b tc=%b, want 3/0/0",
                 k, bus.out, bus.busy, bus.tc);
      end
    end
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    wait_tc(10 * P, lat);
    n_cmp++;
    if (lat !== 3 * P) begin
      n_bad++;
      $display("FAIL resume_latency: got %0d cycles, want %0d", lat, 3 * P);
    end
    // en low for two cycles mid-count delays tc by exactly two.
    set_in(1, 1, 5, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    lat = -1;
    for (int k = 1; k <= 20 * P; k++) begin
      set_in(!(k == P + 2 || k == P + 3), 0, 0, 0, 0, 0);
      clk_cycle();
      if (bus.tc === 1'b1) begin lat = k; break; end
    end
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (lat !== 5 * P + 2) begin
      n_bad++;
      $display("FAIL en_gap_latency: got %0d cycles, want %0d", lat, 5 * P + 2);
    end
  endtask

  task automatic test_collisions();
    int lat;
    // load on the terminal-tick edge
    set_in(1, 1, 1, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (P - 1) clk_cycle();
    set_in(1, 1, 7, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.out, bus.busy, bus.tc, bus.done} !== {8'd7, 3'b000}) begin
      n_bad++;
      $display("FAIL load_vs_tc: got out=%0d busy=%b tc=%b done=%b, want 7/0/0/0",
               bus.out, bus.busy, bus.tc, bus.done);
    end
    clk_cycle();
    n_cmp++;
    if (bus.tc !== 1'b0 || bus.out !== 8'd7) begin
      n_bad++;
      $display("FAIL load_vs_tc_after: got out=%0d tc=%b, want 7/0", bus.out, bus.tc);
    end
    // stop on the terminal-tick edge
    set_in(1, 1, 1, 0, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (P - 1) clk_cycle();
    set_in(1, 0, 0, 0, 1, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.out, bus.busy, bus.tc, bus.done} !== {8'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL stop_vs_tc: got out=%0d busy=%b tc=%b done=%b, want 1/0/0/0",
               bus.out, bus.busy, bus.tc, bus.done);
    end
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    wait_tc(4 * P, lat);
    n_cmp++;
    if (lat !== P) begin
      n_bad++;
      $display("FAIL stop_resume_latency: got %0d cycles, want %0d", lat, P);
    end
    // start and stop together in RUN
    set_in(1, 0, 0, 1, 0, 0); clk_cycle();
    set_in(1, 0, 0, 1, 1, 0); clk_cycle();
    set_in(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.out, bus.busy, bus.tc, bus.done} !== {8'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL start_stop_run: got out=%0d busy=%b tc=%b done=%b, want 1/0/0/0",
               bus.out, bus.busy, bus.tc, bus.done);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_in($urandom_range(0, 9) != 0,
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 9)),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 1) == 1);
      clk_cycle();
      exp = {DW'(m_count), m_run, m_tc, m_done};
      n_cmp++;
      if ({bus.out, bus.busy, bus.tc, bus.done} !== exp) begin
        n_bad++;
        $display("FAIL random k=%0d: got {out,busy,tc,done}=%h, want %h",
                 k, {bus.out, bus.busy, bus.tc, bus.done}, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_count = 0; m_reload = 0; m_pre = 0;
    m_run = 0; m_armed = 0; m_fin = 0; m_tc = 0; m_done = 0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause_resume();
    test_collisions();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, programmable down-counter with a control state machine and a terminal-count pulse, the consuming end of the team's up-counter. It counts a software/FSM-supplied value down to zero, then either stops (one-shot) or reloads (periodic). It sits beside `counter` in the library as the timeout/interval generator for control logic.

## Interface

- `DATA_WIDTH`, 8, width of the count and reload value
- `PRESCALE`, 4, cycles per count tick when `COUNTDOWN_PRESCALE_EN` is defined; legal range 1..65535, otherwise ignored
- `clk` in 1, single clock; all logic on its rising edge
- `rst` in 1, synchronous reset, active-high
- `en` in 1, count enable; counting only advances in cycles with `en`=1
- `load` in 1, load `load_val` into the reload and count registers
- `load_val` in DATA_WIDTH, reload value N
- `start` in 1, start or resume counting
- `stop` in 1, pause counting
- `periodic` in 1, 1 = reload at terminal count, 0 = one-shot; sampled every cycle
- `out` out DATA_WIDTH, current count (registered)
- `busy` out 1, high while in RUN
- `tc` out 1, one-cycle terminal-count pulse
- `done` out 1, sticky one-shot completion flag

## Operation

- States: IDLE, ARMED, RUN, DONE.
- Reset values: state IDLE, `out`=0, reload register=0, prescaler=0, `busy`=0, `tc`=0, `done`=0.
- Per-cycle priority: `rst` > `load` > `stop` > `start` > counting.
- `load`, in any state:
  - reload register and `out` take `load_val`.
  - State goes to ARMED; `done` and the prescaler clear.
  - Mid-RUN, `load` aborts the run with no `tc`.
- `stop`:
  - In RUN, go to ARMED and hold `out`.
  - In any other state, no effect.
- `start`:
  - In ARMED, go to RUN and resume from the current `out`.
  - In DONE, go to RUN with `out` set to the reload value and `done` cleared.
  - In IDLE or RUN, ignored.
- Tick: in RUN with `en`=1. With the macro, a tick also requires the prescaler to wrap (see Configuration).
- Tick with `out` > 1: `out` decrements by 1.
- Tick with `out` ≤ 1 (the terminal tick): `tc`=1 for exactly one cycle, then:
  - `periodic`=1: `out` takes the reload value and state stays RUN. A reload of 0 or 1 therefore gives `tc` on every tick.
  - `periodic`=0: `out`=0, state goes to DONE, `done`=1, `busy`=0.
- Counting never wraps below 0. Arithmetic is unsigned, DATA_WIDTH bits.
- `tc` is 0 in every cycle other than the one after a terminal tick.
- `done` stays set until a `load`, a `start` from DONE, or `rst`.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Edges: `start` is sampled at edge E0, and `busy`=1 from the cycle after E0.
- With `en` held at 1 and no prescaler, count N ≥ 1 reaches terminal at edge EN:
  - `tc`, `done` and `busy`=0 are visible in the cycle after EN.
  - One-shot latency from `start` to `tc` is N cycles; periodic `tc` spacing is max(N,1) ticks.
- A `load` at edge E makes `out`=`load_val` visible after E.
- If `load` coincides with a terminal tick, `load` wins: no `tc`, no `done`.
- If `stop` coincides with a terminal tick, `stop` wins: `out` is held, there is no `tc`, and the next `start` completes the count.
- `en`=0 freezes the count and the prescaler, but not the FSM transitions driven by `load`, `start` or `stop`.

## Configuration

- `COUNTDOWN_PRESCALE_EN` defined:
  - A prescaler counter of width clog2(PRESCALE) (minimum 1 bit) advances when in RUN with `en`=1.
  - A tick occurs when it wraps at PRESCALE-1, so one tick happens every PRESCALE enabled cycles.
  - The prescaler clears on `rst`, `load`, and any `start` that enters RUN.
  - One-shot latency becomes N×PRESCALE cycles.
- Not defined: no prescaler logic; every enabled RUN cycle is a tick and `PRESCALE` is unused.

## Test plan

- Reset: assert `rst` mid-RUN with `out`=5 → next cycle `out`=0, `busy`=`tc`=`done`=0, IDLE; `start` is then ignored.
- One-shot: `load_val`=3, `load`, then `start`, `en`=1, `periodic`=0 → `out` goes 3,2,1,0; `tc` is a single pulse 3 cycles after `busy` rises; `done`=1 and holds until the next `start`.
- Periodic: `load_val`=2, `periodic`=1 → `tc` every 2 cycles, `out` cycles 2,1,2,1,…; load 0 → `tc` every cycle.
- Pause/resume: N=5, `stop` after 2 ticks → `out`=3 held for 4 cycles with `en`=1; `start` → `tc` 3 cycles later. Drop `en` for 2 cycles mid-count → `tc` delayed by exactly 2.
- Collisions: `load`(7) on the terminal-tick cycle → no `tc`, `out`=7, ARMED. `stop` and `start` together in RUN → ARMED.
- With `COUNTDOWN_PRESCALE_EN` and PRESCALE=4: N=3 one-shot → `tc` 12 cycles after `busy` rises; `out` steps every 4 cycles.
